// File: rtl/game_master_fsm_if.sv
// game_master_fsm_if: buttons, mode switch and score/timer status going into
// the game master, plus the game state, mode and clear pulse coming out.
// The master side drives the inputs (board / score stage), the slave side is
// the game master itself.
interface game_master_fsm_if;
  logic       BTN_START;
  logic       BTN_ABORT;
  logic       MODE_SW;
  logic       LOST;
  logic       SCORE_WIN;
  logic [1:0] MSM_STATE;
  logic       Timed_Mode;
  logic       GAME_CLR;

  modport master (
    output BTN_START, BTN_ABORT, MODE_SW, LOST, SCORE_WIN,
    input  MSM_STATE, Timed_Mode, GAME_CLR
  );

  modport slave (
    input  BTN_START, BTN_ABORT, MODE_SW, LOST, SCORE_WIN,
    output MSM_STATE, Timed_Mode, GAME_CLR
  );
endinterface

// File: rtl/game_master_fsm.sv
// game_master_fsm: top-level game state machine (IDLE / PLAY / WIN / LOSE).
// Both push-buttons are synchronized, optionally debounced and turned into
// one-cycle press pulses that drive the FSM. GAME_CLR pulses on every
// transition into PLAY and back into IDLE.
// Optional feature: define GAME_MASTER_FSM_DEBOUNCE_EN to insert a
// DEBOUNCE_MAX+1 cycle stability filter after each synchronizer.
module game_master_fsm #(
  parameter int DEBOUNCE_MAX = 999999
) (
  input logic              CLK,
  input logic              RESET,
  game_master_fsm_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WIN  = 2'd2,
    LOSE = 2'd3
  } gameState_t;

  // Bit 0 is the start button, bit 1 the abort button throughout.
  logic [1:0] btnRaw;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] clean;
  logic [1:0] cleanPrev;
  logic [1:0] armed;
  logic [1:0] press;
  logic [1:0] syncFill;

  gameState_t state;
  gameState_t stateNext;
  logic       timedMode;
  logic       modeNext;
  logic       gameClr;
  logic       clrNext;

  logic startPress;
  logic abortPress;

  assign btnRaw     = {bus.BTN_ABORT, bus.BTN_START};
  assign startPress = press[0];
  assign abortPress = press[1];

  // Two-flop synchronizer per button; syncFill tracks when sync2 holds a real sample again after reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1    <= '0;
      sync2    <= '0;
      syncFill <= '0;
    end else begin
      sync1    <= btnRaw;
      sync2    <= sync1;
      syncFill <= {syncFill[0], 1'b1};
    end
  end

`ifdef GAME_MASTER_FSM_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_MAX < 1) ? 1 : $clog2(DEBOUNCE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_MAX);

  logic [CNT_W-1:0] dbCnt [2];

  // Debounce: the clean level follows the synchronized level only after DEBOUNCE_MAX+1 consecutive differing cycles.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      clean    <= '0;
      dbCnt[0] <= '0;
      dbCnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == clean[i]) begin
          dbCnt[i] <= '0;
        end else if (dbCnt[i] == CNT_MAX) begin
          clean[i] <= sync2[i];
          dbCnt[i] <= '0;
        end else begin
          dbCnt[i] <= dbCnt[i] + CNT_W'(1);
        end
      end
    end
  end
`else
  assign clean = sync2;
`endif

  // Press detector: a button only arms once it has been seen released after reset, so a button held through reset never counts.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cleanPrev <= '0;
      armed     <= '0;
      press     <= '0;
    end else begin
      cleanPrev <= clean;
      armed     <= armed | ({2{syncFill[1]}} & ~sync2);
      press     <= armed & clean & ~cleanPrev;
    end
  end

  // Game state, latched mode and registered clear pulse.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      timedMode <= 1'b0;
      gameClr   <= 1'b0;
    end else begin
      state     <= stateNext;
      timedMode <= modeNext;
      gameClr   <= clrNext;
    end
  end

  // Next-state logic: abort beats everything, LOST beats SCORE_WIN, start is ignored while playing.
  always_comb begin
    stateNext = state;
    modeNext  = timedMode;
    clrNext   = 1'b0;
    case (state)
      IDLE: begin
        if (startPress) begin
          stateNext = PLAY;
          modeNext  = bus.MODE_SW;
          clrNext   = 1'b1;
        end
      end
      PLAY: begin
        if (abortPress) begin
          stateNext = IDLE;
          clrNext   = 1'b1;
        end else if (bus.LOST) begin
          stateNext = LOSE;
        end else if (bus.SCORE_WIN) begin
          stateNext = WIN;
        end
      end
      WIN, LOSE: begin
        if (abortPress || startPress) begin
          stateNext = IDLE;
          clrNext   = 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign bus.MSM_STATE  = state;
  assign bus.Timed_Mode = timedMode;
  assign bus.GAME_CLR   = gameClr;

endmodule

// File: tb/tb_game_master_fsm.sv
// tb_game_master_fsm: randomized directed sequence for game_master_fsm.
// Expected state, mode and clear pulse come from a transaction-level model of
// the game rules; button latency is derived from the build configuration
// (GAME_MASTER_FSM_DEBOUNCE_EN) with DEBOUNCE_MAX fixed at 3.
module tb_game_master_fsm;

  localparam int DB_MAX = 3;
`ifdef GAME_MASTER_FSM_DEBOUNCE_EN
  localparam bit DB_ON = 1'b1;
  localparam int LAT   = DB_MAX + 4;
`else
  localparam bit DB_ON = 1'b0;
  localparam int LAT   = 3;
`endif

  localparam int ST_IDLE = 0;
  localparam int ST_PLAY = 1;
  localparam int ST_WIN  = 2;
  localparam int ST_LOSE = 3;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  int checks = 0;
  int errors = 0;
  int expState = ST_IDLE;
  bit expMode = 1'b0;

  game_master_fsm_if gmIf ();

  game_master_fsm #(.DEBOUNCE_MAX(DB_MAX)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (gmIf)
  );

  // 100 MHz clock
  always #5 CLK = ~CLK;

  // Hard time limit so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input bit expClr);
    checkOutput({tag, ".state"}, {6'd0, gmIf.MSM_STATE}, 8'(expState));
    checkOutput({tag, ".mode"}, {7'd0, gmIf.Timed_Mode}, {7'd0, expMode});
    checkOutput({tag, ".clr"}, {7'd0, gmIf.GAME_CLR}, {7'd0, expClr});
  endtask

  // Game rules applied to one clock edge's worth of events
  task automatic modelStep(input bit startP, input bit abortP, input bit lostLvl, input bit winLvl, output bit clr);
    int prev;
    prev = expState;
    case (expState)
      ST_IDLE: begin
        if (startP) begin
          expState = ST_PLAY;
          expMode  = gmIf.MODE_SW;
        end
      end
      ST_PLAY: begin
        if (abortP) expState = ST_IDLE;
        else if (lostLvl) expState = ST_LOSE;
        else if (winLvl) expState = ST_WIN;
      end
      default: begin
        if (abortP || startP) expState = ST_IDLE;
      end
    endcase
    clr = (expState != prev) && (expState == ST_IDLE || prev == ST_IDLE);
  endtask

  // Hold one button for 'hold' cycles, then release and let it settle.
  // The press reaches the FSM LAT+1 edges after the raw rise.
  task automatic applyStimulus(input bit isAbort, input int hold, input bit lostAtPress, input string tag);
    bit clr;
    if (isAbort) gmIf.BTN_ABORT = 1'b1;
    else gmIf.BTN_START = 1'b1;
    for (int c = 1; c <= hold; c++) begin
      tick();
      if (c == LAT + 1) begin
        modelStep(!isAbort, isAbort, gmIf.LOST, gmIf.SCORE_WIN, clr);
        checkAll(tag, clr);
        gmIf.LOST = 1'b0;
      end else begin
        checkAll(tag, 1'b0);
      end
      if (c == LAT && lostAtPress) gmIf.LOST = 1'b1;
    end
    gmIf.BTN_START = 1'b0;
    gmIf.BTN_ABORT = 1'b0;
    for (int c = 0; c < LAT + 2; c++) begin
      tick();
      checkAll({tag, ".release"}, 1'b0);
    end
  endtask

  // Apply score/timer levels for one cycle, then drop them
  task automatic applyLevels(input bit lostLvl, input bit winLvl, input string tag);
    bit clr;
    gmIf.LOST      = lostLvl;
    gmIf.SCORE_WIN = winLvl;
    tick();
    modelStep(1'b0, 1'b0, lostLvl, winLvl, clr);
    checkAll(tag, clr);
    gmIf.LOST      = 1'b0;
    gmIf.SCORE_WIN = 1'b0;
    tick();
    checkAll({tag, ".after"}, 1'b0);
  endtask

  // Short raw pulse on the start button; only survives without debounce
  task automatic applyGlitch(input int len);
    bit clr;
    bit passes;
    passes = !DB_ON || (len > DB_MAX);
    gmIf.BTN_START = 1'b1;
    for (int c = 1; c <= len + LAT + 4; c++) begin
      tick();
      if (c == LAT + 1) begin
        modelStep(passes, 1'b0, 1'b0, 1'b0, clr);
        checkAll("glitch", clr);
      end else begin
        checkAll("glitch", 1'b0);
      end
      if (c == len) gmIf.BTN_START = 1'b0;
    end
  endtask

  initial begin
    int ending;
    gmIf.BTN_START = 1'b0;
    gmIf.BTN_ABORT = 1'b0;
    gmIf.MODE_SW   = 1'b0;
    gmIf.LOST      = 1'b0;
    gmIf.SCORE_WIN = 1'b0;
    RESET = 1'b1;
    $display("[TB] start, debounce=%0d latency=%0d", DB_ON, LAT);

    repeat (3) tick();
    checkAll("reset", 1'b0);
    RESET = 1'b0;
    repeat (4) begin
      tick();
      checkAll("idleAfterReset", 1'b0);
    end

    // Start button held through reset release must not start a game
    RESET = 1'b1;
    gmIf.BTN_START = 1'b1;
    tick();
    tick();
    checkAll("heldReset.inReset", 1'b0);
    RESET = 1'b0;
    for (int c = 0; c < LAT + 6; c++) begin
      tick();
      checkAll("heldReset", 1'b0);
    end
    gmIf.BTN_START = 1'b0;
    for (int c = 0; c < LAT + 2; c++) begin
      tick();
      checkAll("heldReset.release", 1'b0);
    end

    // Randomized games; first four cover every ending once
    for (int g = 0; g < 7; g++) begin
      gmIf.MODE_SW = (g == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      applyStimulus(1'b0, (g == 0) ? 50 : $urandom_range(LAT + 2, LAT + 12), 1'b0, "start");

      gmIf.MODE_SW = ~gmIf.MODE_SW;
      tick();
      checkAll("modeToggle", 1'b0);

      if ($urandom_range(0, 1) == 1) applyStimulus(1'b0, LAT + 2, 1'b0, "startInPlay");

      ending = (g < 4) ? g : $urandom_range(0, 3);
      case (ending)
        0: applyLevels(1'b1, 1'b0, "lost");
        1: applyLevels(1'b0, 1'b1, "win");
        2: applyLevels(1'b1, 1'b1, "lostAndWin");
        default: applyStimulus(1'b1, $urandom_range(LAT + 2, LAT + 6), 1'b1, "abortWithLost");
      endcase

      if (expState != ST_IDLE) begin
        applyLevels(1'b1, 1'b1, "levelsIgnored");
        applyStimulus(1'($urandom_range(0, 1)), $urandom_range(LAT + 2, LAT + 8), 1'b0, "ack");
      end

      applyStimulus(1'b1, LAT + 2, 1'b0, "abortInIdle");
    end

    // Short start glitches in IDLE
    for (int i = 0; i < 3; i++) begin
      applyGlitch($urandom_range(1, DB_MAX));
      if (expState != ST_IDLE) applyStimulus(1'b1, LAT + 2, 1'b0, "glitchAbort");
    end

    // Reset in the middle of a game, with a press being filtered and LOST high
    gmIf.MODE_SW = 1'b1;
    applyStimulus(1'b0, LAT + 3, 1'b0, "preReset");
    gmIf.BTN_START = 1'b1;
    tick();
    tick();
    RESET = 1'b1;
    gmIf.LOST = 1'b1;
    tick();
    expState = ST_IDLE;
    expMode  = 1'b0;
    checkAll("midReset", 1'b0);
    RESET = 1'b0;
    gmIf.LOST = 1'b0;
    for (int c = 0; c < LAT + 4; c++) begin
      tick();
      checkAll("afterMidReset", 1'b0);
    end
    gmIf.BTN_START = 1'b0;
    for (int c = 0; c < LAT + 2; c++) begin
      tick();
      checkAll("afterMidReset.release", 1'b0);
    end
    gmIf.MODE_SW = 1'b0;
    applyStimulus(1'b0, LAT + 3, 1'b0, "restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
